ks_sum: RTL and testbench

- Final, registered stage of the 24-bit Kogge-Stone adder. Sits directly downstream of the last prefix stage (stage 6).
- Consumes the fully resolved group-generate vector, the saved propagate bits and the carry-in. Forms the sum, carry-out and a zero flag.
- Registers the result behind a valid/ready handshake with a skid buffer, so the adder can be back-pressured by the consumer (normaliser/rounding).

---
 rtl/ks_pkg.sv | 26 ++
 rtl/ks_skid.sv | 78 +++++++
 rtl/ks_sum.sv | 65 ++++++
 tb/tb_ks_sum.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// rtl/ks_pkg.sv - shared types and constants for the ks_* Kogge-Stone adder stages
//
// Purpose: common width, result payload and skid-buffer state encoding used by
//          every ks_* stage.
// Contents:
//   KS_W             operand width of the adder
//   ks_res_t         registered result payload {sum, cout, zero}
//   ks_skid_state_e  occupancy of a 2-entry skid register, encoded {main_valid, skid_valid}
package ks_pkg;

  localparam int KS_W = 24;

  typedef struct packed {
    logic [KS_W-1:0] sum;
    logic            cout;
    logic            zero;
  } ks_res_t;

  // Encoded as {main_valid, skid_valid} so the valid bits fall straight out of the state.
  typedef enum logic [1:0] {
    KS_EMPTY = 2'b00,
    KS_ONE   = 2'b10,
    KS_FULL  = 2'b11
  } ks_skid_state_e;

endpackage

// File: rtl/ks_skid.sv
// rtl/ks_skid.sv - 2-entry valid/ready skid register (main + skid) for a typed payload
//
// Purpose: registers a payload behind a valid/ready handshake. o_ready depends
//          only on registered state, so there is no combinational path from
//          i_ready back to o_ready.
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset; clears both entries and payloads
//   i_valid  upstream word valid
//   o_ready  can accept a word this cycle (skid entry empty)
//   i_data   upstream payload
//   o_valid  main entry holds a word
//   i_ready  downstream accepts the word
//   o_data   main entry payload
module ks_skid
  import ks_pkg::*;
#(
  parameter type T = ks_res_t
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  ks_skid_state_e r_state;
  T               r_main;
  T               r_skid;

  logic w_accept;
  logic w_xfer;

  assign o_valid  = (r_state != KS_EMPTY);
  assign o_ready  = (r_state != KS_FULL);
  assign o_data   = r_main;
  assign w_accept = i_valid & o_ready;
  assign w_xfer   = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= KS_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        KS_EMPTY: begin
          if (w_accept) begin
            r_main  <= i_data;
            r_state <= KS_ONE;
          end
        end
        KS_ONE: begin
          if (w_accept && w_xfer) begin
            r_main <= i_data;
          end else if (w_accept) begin
            // Consumer stalled: park the new word behind the one in main.
            r_skid  <= i_data;
            r_state <= KS_FULL;
          end else if (w_xfer) begin
            r_state <= KS_EMPTY;
          end
        end
        KS_FULL: begin
          if (w_xfer) begin
            r_main  <= r_skid;
            r_state <= KS_ONE;
          end
        end
        default: r_state <= KS_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ks_sum.sv
// rtl/ks_sum.sv - final registered sum stage of the 24-bit Kogge-Stone adder
//
// Purpose: forms sum, carry-out and zero flag from the resolved group-generate
//          vector, saved propagate bits and carry-in, then registers the
//          result behind a back-pressurable skid register.
// Ports:
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset
//   i_valid   upstream word valid
//   o_ready   this block can accept a word this cycle
//   i_c0      adder carry-in
//   i_gk      group generate, i_gk[k] = G[k:0] with carry-in folded in
//   i_p_save  bitwise propagate a^b
//   o_valid   output word valid
//   i_ready   downstream accepts the word
//   o_sum     sum bits
//   o_cout    carry out of bit W-1
//   o_zero    o_sum == 0
module ks_sum
  import ks_pkg::*;
#(
  parameter int W = KS_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_c0,
  input  logic [W-1:0] i_gk,
  input  logic [W-1:0] i_p_save,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_zero
);

  logic [W-1:0] w_sum;
  ks_res_t      w_res;
  ks_res_t      w_out;

  // Carry into bit k is G[k-1:0]; bit 0 takes the raw carry-in.
  assign w_sum      = i_p_save ^ {i_gk[W-2:0], i_c0};
  assign w_res.sum  = w_sum;
  assign w_res.cout = i_gk[W-1];
  assign w_res.zero = ~|w_sum;

  ks_skid #(
    .T(ks_res_t)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (w_res),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (w_out)
  );

  assign o_sum  = w_out.sum;
  assign o_cout = w_out.cout;
  assign o_zero = w_out.zero;

endmodule

// File: tb/tb_ks_sum.sv
// tb/tb_ks_sum.sv - self-checking bench for ks_sum
module tb_ks_sum;

  localparam int W = 24;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic         c0;
  logic [W-1:0] gk;
  logic [W-1:0] p_save;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_zero;

  int checks;
  int failures;

  ks_sum #(.W(W)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_c0     (c0),
    .i_gk     (gk),
    .i_p_save (p_save),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_sum    (o_sum),
    .o_cout   (o_cout),
    .o_zero   (o_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Group generate from operands: gk[k] is the carry out of bit k of a+b+c0.
  function automatic logic [W-1:0] gk_of(logic [W-1:0] a, logic [W-1:0] b, logic cin);
    logic [W-1:0] r;
    logic [W:0]   m;
    logic [W:0]   s;
    for (int k = 0; k < W; k++) begin
      m = (25'd1 << (k + 1)) - 25'd1;
      s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, cin};
      r[k] = s[k+1];
    end
    return r;
  endfunction

  // Expected {sum, cout, zero} from the plain arithmetic sum.
  function automatic logic [W+1:0] expect_of(logic [W-1:0] a, logic [W-1:0] b, logic cin);
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    return {t[W-1:0], t[W], (t[W-1:0] == '0)};
  endfunction

  task automatic drive_ab(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    gk     = gk_of(a, b, cin);
    p_save = a ^ b;
    c0     = cin;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b1; i_ready = 1'b0;
    drive_ab(24'h123456, 24'h111111, 1'b1);
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_during got=%b want=1", o_ready); end
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0;
    checks++;
    if ({o_valid, o_sum, o_cout, o_zero} !== '0)
      begin failures++; $display("FAIL reset_outputs got v=%b s=%h c=%b z=%b want all 0", o_valid, o_sum, o_cout, o_zero); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1)
      begin failures++; $display("FAIL reset_after got v=%b r=%b want v=0 r=1", o_valid, o_ready); end
  endtask

  task automatic test_directed;
    logic [W-1:0] tgk [3]   = '{24'h00FFFF, 24'hFFFFFF, 24'h000000};
    logic [W-1:0] tp  [3]   = '{24'h00FFFE, 24'hFFFFFE, 24'h000000};
    logic         tc  [3]   = '{1'b0, 1'b0, 1'b1};
    logic [W+1:0] texp [3]  = '{{24'h010000, 1'b0, 1'b0}, {24'h000000, 1'b1, 1'b1}, {24'h000001, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_valid = 1'b1; i_ready = 1'b1; gk = tgk[i]; p_save = tp[i]; c0 = tc[i];
      @(negedge clk);
      i_valid = 1'b0; gk = 'x; p_save = 'x; c0 = 1'bx;
      checks++;
      if (o_valid !== 1'b1 || {o_sum, o_cout, o_zero} !== texp[i])
        begin failures++; $display("FAIL directed_%0d got v=%b %h/%b/%b want v=1 %h", i, o_valid, o_sum, o_cout, o_zero, texp[i]); end
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL directed_drain got v=%b want 0", o_valid); end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] a [3] = '{24'h000010, 24'h000020, 24'h000030};
    logic [W-1:0] b [3] = '{24'h000001, 24'h000002, 24'h000003};
    @(negedge clk);
    i_ready = 1'b0; i_valid = 1'b1; drive_ab(a[0], b[0], 1'b0);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_ready !== 1'b1 || o_sum !== 24'h000011)
      begin failures++; $display("FAIL bp_a_main got v=%b r=%b s=%h want v=1 r=1 s=000011", o_valid, o_ready, o_sum); end
    drive_ab(a[1], b[1], 1'b0);
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b0 || o_sum !== 24'h000011)
      begin failures++; $display("FAIL bp_full got r=%b s=%h want r=0 s=000011", o_ready, o_sum); end
    drive_ab(a[2], b[2], 1'b0);
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_sum !== 24'h000011)
      begin failures++; $display("FAIL bp_hold got r=%b v=%b s=%h want r=0 v=1 s=000011", o_ready, o_valid, o_sum); end
    i_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 24'h000022 || o_ready !== 1'b1)
      begin failures++; $display("FAIL bp_out_b got v=%b s=%h r=%b want v=1 s=000022 r=1", o_valid, o_sum, o_ready); end
    @(negedge clk);
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 24'h000033)
      begin failures++; $display("FAIL bp_out_c got v=%b s=%h want v=1 s=000033", o_valid, o_sum); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got v=%b want 0", o_valid); end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    i_ready = 1'b0; i_valid = 1'b1; drive_ab(24'h0000AA, 24'h000001, 1'b0);
    @(negedge clk);
    drive_ab(24'h0000BB, 24'h000001, 1'b0);
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b0) begin failures++; $display("FAIL mid_full got r=%b want 0", o_ready); end
    rst = 1'b1; drive_ab(24'h0000DD, 24'h000001, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_sum !== '0 || o_cout !== 1'b0 || o_zero !== 1'b0 || o_ready !== 1'b1)
      begin failures++; $display("FAIL mid_reset got v=%b s=%h c=%b z=%b r=%b want v=0 s=0 c=0 z=0 r=1", o_valid, o_sum, o_cout, o_zero, o_ready); end
    i_ready = 1'b1; drive_ab(24'h000EEE, 24'h000001, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_sum !== 24'h000EEF)
      begin failures++; $display("FAIL mid_next got v=%b s=%h want v=1 s=000EEF", o_valid, o_sum); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL mid_residue got v=%b s=%h want v=0", o_valid, o_sum); end
  endtask

  task automatic test_random;
    logic [W+1:0] q[$];
    logic [W-1:0] a, b;
    logic         cin;
    logic         pending;
    logic         prev_stall;
    logic [W+1:0] prev_out;
    int           sent;
    int           cycles;
    sent = 0; cycles = 0; pending = 1'b0; prev_stall = 1'b0; prev_out = '0;
    a = '0; b = '0; cin = 1'b0;
    while ((sent < 10000 || pending || q.size() != 0) && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      if (o_valid !== (q.size() > 0) || o_ready !== (q.size() < 2)) begin
        failures++;
        $display("FAIL rand_flags got v=%b r=%b want occupancy=%0d", o_valid, o_ready, q.size());
      end
      checks++;
      if (prev_stall) begin
        checks++;
        if ({o_sum, o_cout, o_zero} !== prev_out)
          begin failures++; $display("FAIL rand_stable got %h want %h", {o_sum, o_cout, o_zero}, prev_out); end
      end
      i_ready = ($urandom_range(0, 3) != 0);
      if (!pending && sent < 10000 && $urandom_range(0, 3) != 0) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        pending = 1'b1;
      end
      i_valid = pending;
      if (pending) drive_ab(a, b, cin);
      else begin gk = 'x; p_save = 'x; c0 = 1'bx; end
      prev_stall = o_valid & ~i_ready;
      prev_out   = {o_sum, o_cout, o_zero};
      if (o_valid && i_ready && q.size() > 0) begin
        checks++;
        if ({o_sum, o_cout, o_zero} !== q[0])
          begin failures++; $display("FAIL rand_data got %h want %h", {o_sum, o_cout, o_zero}, q[0]); end
        void'(q.pop_front());
      end
      if (i_valid && o_ready) begin
        q.push_back(expect_of(a, b, cin));
        pending = 1'b0;
        sent++;
      end
    end
    checks++;
    if (sent != 10000 || q.size() != 0 || pending)
      begin failures++; $display("FAIL rand_timeout sent=%0d left=%0d want sent=10000 left=0", sent, q.size()); end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; gk = '0; p_save = '0; c0 = 1'b0;
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_midstream;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
